// File: rtl/readout_seq_t7_if.sv
`default_nettype none
`timescale 1ns / 1ps
// ============================================================================
//  Module   : readout_seq_t7_if
//  Brief    : Exposure trigger/busy handshake and row valid/ready handoff.
//  Revision : 1.0  initial release
// ============================================================================
interface readout_seq_t7_if #(
    parameter int ROW_W = 9
) ();
    logic             trigger_i;
    logic             re_busy;
    logic             row_valid;
    logic             row_ready;
    logic [ROW_W-1:0] row_idx;
    logic             frame_done;

    // Sequencer side
    modport master (
        input  trigger_i,
        input  row_ready,
        output re_busy,
        output row_valid,
        output row_idx,
        output frame_done
    );

    // Exposure controller / packer side
    modport slave (
        output trigger_i,
        output row_ready,
        input  re_busy,
        input  row_valid,
        input  row_idx,
        input  frame_done
    );
endinterface
`default_nettype wire

// File: rtl/readout_seq_t7.sv
`default_nettype none
`timescale 1ns / 1ps
// ============================================================================
//  Module   : readout_seq_t7
//  Brief    : Row-readout sequencer: row select, sample/hold, ADC start and
//             per-row valid/ready handoff, busy until the trigger drops.
//  Revision : 1.0  initial release
// ============================================================================
module readout_seq_t7 #(
    parameter int ROW_W = 9
) (
    input  wire logic             CLKM,
    input  wire logic             rst_n,
    input  wire logic [31:0]      NUM_ROW,
    input  wire logic [31:0]      Tset,
    input  wire logic [31:0]      Tsh,
    input  wire logic [31:0]      Tconv,
    output logic      [ROW_W-1:0] ROWADD_RD,
    output logic                  PIXREAD_EN,
    output logic                  PIX_SH,
    output logic                  ADC_START,
    readout_seq_t7_if.master      bus
);

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_ROW_SETUP = 3'd1;
    localparam logic [2:0] c_SAMPLE    = 3'd2;
    localparam logic [2:0] c_CONVERT   = 3'd3;
    localparam logic [2:0] c_HANDOFF   = 3'd4;
    localparam logic [2:0] c_DONE      = 3'd5;

    localparam logic [31:0]      c_MAX_ROWS = 32'd1 << ROW_W;
    localparam logic [ROW_W:0]   c_NUM_ONE  = 1;
    localparam logic [ROW_W-1:0] c_ROW_ONE  = 1;

    logic [2:0]       r_state;
    logic [31:0]      r_cnt;
    logic [ROW_W-1:0] r_row;
    logic [ROW_W:0]   r_num_rows;
    logic [31:0]      r_tset;
    logic [31:0]      r_tsh;
    logic [31:0]      r_tconv;

    logic [ROW_W-1:0] r_rowadd_rd;
    logic             r_pixread_en;
    logic             r_pix_sh;
    logic             r_adc_start;
    logic             r_re_busy;
    logic             r_row_valid;
    logic [ROW_W-1:0] r_row_idx;
    logic             r_frame_done;

    logic [2:0]       w_state_nxt;
    logic [31:0]      w_cnt_nxt;
    logic [ROW_W-1:0] w_row_nxt;
    logic [ROW_W:0]   w_rows_in;
    logic             w_last_row;

    logic [ROW_W-1:0] w_rowadd_rd;
    logic             w_pixread_en;
    logic             w_pix_sh;
    logic             w_adc_start;
    logic             w_re_busy;
    logic             w_row_valid;
    logic [ROW_W-1:0] w_row_idx;
    logic             w_frame_done;

    // A programmed time of zero still spends one cycle in its state.
    function automatic logic [31:0] f_load(input logic [31:0] t);
        return (t == 32'd0) ? 32'd0 : (t - 32'd1);
    endfunction

    assign w_rows_in  = (NUM_ROW > c_MAX_ROWS) ? c_MAX_ROWS[ROW_W:0] : NUM_ROW[ROW_W:0];
    assign w_last_row = ({1'b0, r_row} == (r_num_rows - c_NUM_ONE));

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge CLKM or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_IDLE;
            r_cnt        <= '0;
            r_row        <= '0;
            r_num_rows   <= '0;
            r_tset       <= '0;
            r_tsh        <= '0;
            r_tconv      <= '0;
            r_rowadd_rd  <= '0;
            r_pixread_en <= 1'b0;
            r_pix_sh     <= 1'b0;
            r_adc_start  <= 1'b0;
            r_re_busy    <= 1'b0;
            r_row_valid  <= 1'b0;
            r_row_idx    <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_row   <= w_row_nxt;
            // Frame configuration is frozen at the trigger edge.
            if ((r_state == c_IDLE) && bus.trigger_i) begin
                r_num_rows <= w_rows_in;
                r_tset     <= Tset;
                r_tsh      <= Tsh;
                r_tconv    <= Tconv;
            end
            r_rowadd_rd  <= w_rowadd_rd;
            r_pixread_en <= w_pixread_en;
            r_pix_sh     <= w_pix_sh;
            r_adc_start  <= w_adc_start;
            r_re_busy    <= w_re_busy;
            r_row_valid  <= w_row_valid;
            r_row_idx    <= w_row_idx;
            r_frame_done <= w_frame_done;
        end
    end

    // ------------------------------------------------------------------
    // Next state, phase counter and row index
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_row_nxt   = r_row;
        case (r_state)
            c_IDLE: begin
                if (bus.trigger_i) begin
                    w_row_nxt = '0;
                    if (w_rows_in == '0) begin
                        w_state_nxt = c_DONE;
                    end else begin
                        w_state_nxt = c_ROW_SETUP;
                        w_cnt_nxt   = f_load(Tset);
                    end
                end
            end
            c_ROW_SETUP: begin
                if (r_cnt == 32'd0) begin
                    w_state_nxt = c_SAMPLE;
                    w_cnt_nxt   = f_load(r_tsh);
                end else begin
                    w_cnt_nxt = r_cnt - 32'd1;
                end
            end
            c_SAMPLE: begin
                if (r_cnt == 32'd0) begin
                    w_state_nxt = c_CONVERT;
                    w_cnt_nxt   = f_load(r_tconv);
                end else begin
                    w_cnt_nxt = r_cnt - 32'd1;
                end
            end
            c_CONVERT: begin
                if (r_cnt == 32'd0) begin
                    w_state_nxt = c_HANDOFF;
                end else begin
                    w_cnt_nxt = r_cnt - 32'd1;
                end
            end
            c_HANDOFF: begin
                if (bus.row_ready) begin
                    if (w_last_row) begin
                        w_state_nxt = c_DONE;
                    end else begin
                        w_state_nxt = c_ROW_SETUP;
                        w_row_nxt   = r_row + c_ROW_ONE;
                        w_cnt_nxt   = f_load(r_tset);
                    end
                end
            end
            c_DONE: begin
                // Holding here while the trigger is high gives one frame per assertion.
                if (!bus.trigger_i) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode of the state being entered, registered above
    // ------------------------------------------------------------------
    always_comb begin
        w_rowadd_rd  = '0;
        w_pixread_en = 1'b0;
        w_pix_sh     = 1'b0;
        w_adc_start  = 1'b0;
        w_re_busy    = (w_state_nxt != c_IDLE);
        w_row_valid  = 1'b0;
        w_row_idx    = '0;
        w_frame_done = 1'b0;
        case (w_state_nxt)
            c_ROW_SETUP: begin
                w_rowadd_rd  = w_row_nxt;
                w_pixread_en = 1'b1;
            end
            c_SAMPLE: begin
                w_rowadd_rd  = w_row_nxt;
                w_pixread_en = 1'b1;
                w_pix_sh     = 1'b1;
            end
            c_CONVERT: begin
                w_rowadd_rd  = w_row_nxt;
                w_pixread_en = 1'b1;
                w_adc_start  = (r_state != c_CONVERT);
            end
            c_HANDOFF: begin
                w_rowadd_rd = w_row_nxt;
                w_row_valid = 1'b1;
                w_row_idx   = w_row_nxt;
            end
            c_DONE: begin
                w_frame_done = (r_state != c_DONE);
            end
            default: begin
                w_re_busy = (w_state_nxt != c_IDLE);
            end
        endcase
    end

    assign ROWADD_RD      = r_rowadd_rd;
    assign PIXREAD_EN     = r_pixread_en;
    assign PIX_SH         = r_pix_sh;
    assign ADC_START      = r_adc_start;
    assign bus.re_busy    = r_re_busy;
    assign bus.row_valid  = r_row_valid;
    assign bus.row_idx    = r_row_idx;
    assign bus.frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_readout_seq_t7.sv
`default_nettype none
`timescale 1ns / 1ps
// ============================================================================
//  Module   : tb_readout_seq_t7
//  Brief    : Bench for readout_seq_t7 against a per-cycle timeline model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_readout_seq_t7;

    logic        CLKM;
    logic        rst_n;
    logic [31:0] num_row, tset, tsh, tconv;
    logic [8:0]  rowadd_rd;
    logic        pixread_en, pix_sh, adc_start;
    int          n_cmp;
    int          n_err;

    readout_seq_t7_if #(.ROW_W(9)) bus ();

    readout_seq_t7 #(.ROW_W(9)) dut (
        .CLKM       (CLKM),
        .rst_n      (rst_n),
        .NUM_ROW    (num_row),
        .Tset       (tset),
        .Tsh        (tsh),
        .Tconv      (tconv),
        .ROWADD_RD  (rowadd_rd),
        .PIXREAD_EN (pixread_en),
        .PIX_SH     (pix_sh),
        .ADC_START  (adc_start),
        .bus        (bus.master)
    );

    initial CLKM = 1'b0;
    always #2.5 CLKM = ~CLKM;

    initial begin
        #2ms;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Output bundle: {busy,pixen,sh,adc,valid,done,rowadd[8:0],idx[8:0]}
    function automatic logic [23:0] pk(input logic b, input logic p, input logic s,
                                       input logic a, input logic v, input logic d,
                                       input int ra, input int ix);
        return {b, p, s, a, v, d, 9'(ra), 9'(ix)};
    endfunction

    function automatic logic [23:0] observe();
        return {bus.re_busy, pixread_en, pix_sh, adc_start, bus.row_valid,
                bus.frame_done, rowadd_rd, bus.row_idx};
    endfunction

    function automatic int mx1(input int t);
        return (t < 1) ? 1 : t;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Build the expected timeline from row phase durations, then drive and compare.
    // Cycle 0 is the cycle in which trigger is first high; trigger is high for h cycles.
    task automatic run_frame(input int n, input int ts, input int tsh_i, input int tc,
                             input int h, input int smax, input int s0, input int stop,
                             output int busy_cnt, output int done_cnt, output int last_idx);
        logic [23:0] eq[$];
        bit          rq[$];
        int          nr, d, dn, k;
        logic [23:0] obs;
        nr = (n > 512) ? 512 : n;
        eq.push_back('0); rq.push_back(1'($urandom_range(0, 1)));
        for (int r = 0; r < nr; r++) begin
            for (int i = 0; i < mx1(ts); i++) begin
                eq.push_back(pk(1, 1, 0, 0, 0, 0, r, 0)); rq.push_back(1'($urandom_range(0, 1)));
            end
            for (int i = 0; i < mx1(tsh_i); i++) begin
                eq.push_back(pk(1, 1, 1, 0, 0, 0, r, 0)); rq.push_back(1'($urandom_range(0, 1)));
            end
            for (int i = 0; i < mx1(tc); i++) begin
                eq.push_back(pk(1, 1, 0, (i == 0), 0, 0, r, 0)); rq.push_back(1'($urandom_range(0, 1)));
            end
            k = (r == 0 && s0 >= 0) ? s0 : int'($urandom_range(0, smax));
            for (int i = 0; i <= k; i++) begin
                eq.push_back(pk(1, 0, 0, 0, 1, 0, r, r)); rq.push_back(i == k);
            end
        end
        d  = eq.size();
        dn = (h > d) ? (h - d + 1) : 1;
        for (int i = 0; i < dn; i++) begin
            eq.push_back(pk(1, 0, 0, 0, 0, (i == 0), 0, 0)); rq.push_back(1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 2; i++) begin
            eq.push_back('0); rq.push_back(1'($urandom_range(0, 1)));
        end
        num_row = n; tset = ts; tsh = tsh_i; tconv = tc;
        busy_cnt = 0; done_cnt = 0; last_idx = -1;
        for (int c = 0; c < eq.size() && c < stop; c++) begin
            bus.trigger_i = (c < h);
            bus.row_ready = rq[c];
            if (c == 1) begin
                // Mid-frame config changes must not affect this frame.
                num_row = $urandom_range(0, 700);
                tset = $urandom_range(0, 9); tsh = $urandom_range(0, 9); tconv = $urandom_range(0, 9);
            end
            @(negedge CLKM);
            obs = observe();
            check($sformatf("cyc%0d", c), 32'(obs), 32'(eq[c]));
            if (obs[23]) busy_cnt++;
            if (obs[18]) done_cnt++;
            if (obs[19] && bus.row_ready) last_idx = int'(obs[8:0]);
            @(posedge CLKM); #1;
        end
    endtask

    initial begin
        int bc, dc, li;
        int starts, dones, run, overlap;
        n_cmp = 0; n_err = 0;
        rst_n = 1'b0; bus.trigger_i = 1'b0; bus.row_ready = 1'b0;
        num_row = 0; tset = 0; tsh = 0; tconv = 0;
        repeat (3) @(posedge CLKM);
        @(negedge CLKM);
        check("reset", 32'(observe()), 32'd0);
        @(posedge CLKM); #1;
        rst_n = 1'b1;

        run_frame(2, 2, 3, 4, 1, 0, 0, 100000, bc, dc, li);
        check("basic_busy", bc, 21); check("basic_done", dc, 1); check("basic_last", li, 1);

        run_frame(2, 2, 3, 4, 1, 0, 5, 100000, bc, dc, li);
        check("bp_busy", bc, 26); check("bp_done", dc, 1);

        run_frame(1, 1, 1, 1, 100, 0, 0, 100000, bc, dc, li);
        check("held_busy", bc, 100); check("held_done", dc, 1);

        run_frame(3, 0, 0, 0, 1, 0, 0, 100000, bc, dc, li);
        check("zero_busy", bc, 13);

        run_frame(0, 3, 3, 3, 1, 0, 0, 100000, bc, dc, li);
        check("n0_busy", bc, 1); check("n0_done", dc, 1);

        run_frame(1000, 0, 0, 0, 1, 0, 0, 100000, bc, dc, li);
        check("clamp_last", li, 511); check("clamp_busy", bc, 2049);

        for (int f = 0; f < 6; f++) begin
            run_frame($urandom_range(0, 5), $urandom_range(0, 4), $urandom_range(0, 4),
                      $urandom_range(0, 4), $urandom_range(1, 30), 3, -1, 100000, bc, dc, li);
            check($sformatf("rand%0d_done", f), dc, 1);
        end

        // Reset during SAMPLE of row 5 (all times 1: row period 4).
        run_frame(8, 1, 1, 1, 1, 0, 0, 22, bc, dc, li);
        check("r5_sample", {pix_sh, rowadd_rd}, {1'b1, 9'd5});
        rst_n = 1'b0;
        #1;
        check("rst_async", 32'(observe()), 32'd0);
        @(posedge CLKM); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLKM);
            check($sformatf("post_rst%0d", i), 32'(observe()), 32'd0);
        end
        @(posedge CLKM); #1;
        run_frame(2, 1, 1, 1, 1, 1, -1, 100000, bc, dc, li);
        check("restart_done", dc, 1);

        // Closed loop: exposure fires whenever readout is idle.
        num_row = 2; tset = 1; tsh = 2; tconv = 1; bus.row_ready = 1'b1;
        starts = 0; dones = 0; run = 0; overlap = 0;
        for (int c = 0; c < 400; c++) begin
            if (starts == 3 && dones == 3 && !bus.re_busy) break;
            bus.trigger_i = !bus.re_busy && (starts < 3);
            if (bus.trigger_i) starts++;
            @(negedge CLKM);
            if (bus.trigger_i && bus.re_busy) overlap++;
            if (bus.frame_done) dones++;
            if (bus.re_busy) run++;
            else if (run > 0) begin
                check("loop_busy", run, 11);
                run = 0;
            end
            @(posedge CLKM); #1;
        end
        bus.trigger_i = 1'b0;
        check("loop_frames", dones, 3);
        check("loop_overlap", overlap, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/readout_seq_t7.md
# readout_seq_t7

Row-readout sequencer at the receiving end of the exposure/readout handshake. It accepts the exposure controller's `trigger` and holds `re_busy` while it scans the pixel array one row at a time. For each row it drives a row address, a sample-and-hold pulse and an ADC conversion start. It then offers the row to the downstream packer with a valid/ready handshake. It releases `re_busy` only after the last row is accepted and the trigger has dropped, so the exposure controller cannot start the next exposure while readout is still running.

## Interface
Parameters:
- `ROW_W`, default 9: width of the row address and row index; maximum rows = 2^ROW_W.

Ports:
- `CLKM`  in  1  200 MHz system clock; all logic is on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `trigger_i`  in  1  level from the exposure controller's `trigger_o`.
- `re_busy`  out  1  readout busy, returned to the exposure controller.
- `NUM_ROW`  in  32  rows per frame; values above 2^ROW_W are clamped to 2^ROW_W.
- `Tset`  in  32  row-address settle time, in cycles.
- `Tsh`  in  32  sample-and-hold width, in cycles.
- `Tconv`  in  32  conversion time, in cycles.
- `ROWADD_RD`  out  ROW_W  row address being read.
- `PIXREAD_EN`  out  1  row read-select enable.
- `PIX_SH`  out  1  sample-and-hold strobe.
- `ADC_START`  out  1  ADC start, a one-cycle pulse per row.
- `row_valid`  out  1  row result available downstream.
- `row_ready`  in  1  downstream accepts the row.
- `row_idx`  out  ROW_W  index of the row offered on `row_valid`.
- `frame_done`  out  1  one-cycle pulse after the last row is accepted.

## Operation
- All outputs are registered. Each output follows the state the FSM is in during that cycle (Moore).
- `NUM_ROW`, `Tset`, `Tsh` and `Tconv` are latched on the trigger edge. Changes mid-frame have no effect until the next frame.
- Any time value of 0 is treated as 1 cycle. Counters are 32 bits and load `max(T,1)-1`.
- States:
  - **IDLE**
    - Outputs: all deasserted, `re_busy`=0.
    - `trigger_i`=1 → latch config, row=0 → ROW_SETUP, or DONE if the clamped `NUM_ROW`=0.
  - **ROW_SETUP**
    - Outputs: `ROWADD_RD`=row, `PIXREAD_EN`=1.
    - Lasts `max(Tset,1)` cycles → SAMPLE.
  - **SAMPLE**
    - Outputs: `PIXREAD_EN`=1, `PIX_SH`=1.
    - Lasts `max(Tsh,1)` cycles → CONVERT.
  - **CONVERT**
    - Outputs: `PIXREAD_EN`=1; `ADC_START`=1 in the first cycle only.
    - Lasts `max(Tconv,1)` cycles → HANDOFF.
  - **HANDOFF**
    - Outputs: `row_valid`=1, `row_idx`=row, `PIXREAD_EN`=0; `ROWADD_RD` holds.
    - Stays until `row_ready`=1 is sampled.
    - On acceptance: if row = NUM_ROW-1 → DONE, else row+1 → ROW_SETUP.
  - **DONE**
    - `frame_done`=1 in the first cycle only.
    - Stays while `trigger_i`=1; `trigger_i`=0 → IDLE.
- `re_busy`=1 in every state except IDLE.
- Handshake rules:
  - `row_valid` and `row_idx` stay stable until accepted.
  - `row_valid` never drops without `row_ready`.
  - A row is accepted only in a cycle with `row_valid`=1 and `row_ready`=1.
- Holding in DONE while `trigger_i`=1 guarantees one frame per trigger assertion. A level trigger that stays high never causes a second frame.
- `trigger_i` is ignored outside IDLE.

## Timing
- Reset values: `re_busy`=0, `ROWADD_RD`=0, `row_idx`=0, and every other output 0; state=IDLE.
- Reset is effective immediately (asynchronous assertion). Reset mid-frame abandons the frame; no `frame_done` is issued.
- Trigger latency: `trigger_i` sampled high at edge T → at T+1 `re_busy`=1, `PIXREAD_EN`=1, `ROWADD_RD`=0.
- Row period with `row_ready` held at 1: R = max(Tset,1) + max(Tsh,1) + max(Tconv,1) + 1 cycles.
- `ADC_START` rises at row start + max(Tset,1) + max(Tsh,1).
- Frame duration with `trigger_i`=0 by the time DONE is reached: `re_busy` is high for N·R + 1 cycles.
  - `NUM_ROW`=0 → high for exactly 1 cycle.
- Backpressure: each cycle `row_ready` is low in HANDOFF adds exactly one cycle to the frame.

## Test plan
- Basic frame:
  - Stimulus: NUM_ROW=2, Tset=2, Tsh=3, Tconv=4, `row_ready`=1, trigger pulsed high for 1 cycle.
  - Response: `re_busy` high for 21 cycles; `ROWADD_RD` 0 then 1; two `ADC_START` pulses 10 cycles apart; `row_idx` 0,1; one `frame_done`.
- Backpressure:
  - Stimulus: same config, `row_ready` low for 5 cycles during row 0's HANDOFF.
  - Response: `row_valid` and `row_idx`=0 stable throughout; `PIXREAD_EN`=0; `re_busy` high for 26 cycles.
- Held trigger:
  - Stimulus: `trigger_i` held high for 100 cycles, NUM_ROW=1, all times 1.
  - Response: one frame only; `re_busy` stays 1 in DONE until `trigger_i` falls, then drops 1 cycle later.
- Zero and clamp:
  - Stimulus: Tset=Tsh=Tconv=0 with NUM_ROW=3 → R=4, busy 13 cycles.
  - Stimulus: NUM_ROW=0 → busy 1 cycle plus `frame_done`.
  - Stimulus: NUM_ROW=1000 → last `row_idx`=511.
- Reset mid-row:
  - Stimulus: `rst_n` low during SAMPLE of row 5.
  - Response: all outputs 0 immediately; no `frame_done`; the next trigger restarts at row 0.
- Closed loop:
  - Stimulus: connect to a behavioural exposure model (trigger on ~busy, drop trigger on busy).
  - Response: 3 consecutive frames complete with no overlap between exposure and readout.
